// File: rtl/ysyx_25040111_ifu.sv
// Instruction fetch unit: one AXI-lite read outstanding, hands {inst, pc, err} to decode.
// 4 cycles/instruction on a zero-wait bus; holds ifu_valid until ifu_accept, parks in WAIT after a jump or fault.
module ysyx_25040111_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic        rvalid,
  output logic        rready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  output logic [31:0] ifu_inst,
  output logic [31:0] ifu_pc,
  output logic        ifu_valid,
  input  logic        ifu_accept,
  output logic        fetch_err,
  input  logic        jump,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  typedef enum logic [2:0] {IDLE, REQ, RSP, OUT, DEC, WAIT} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] ipc_q, ipc_d;
  logic        err_q, err_d;
  logic        misaligned;

  assign misaligned = (pc_q[1:0] != 2'b00);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = REQ;
      // A misaligned PC never reaches the bus; it is reported as a fetch fault.
      REQ: begin
        if (misaligned) begin
          state_d = OUT;
        end else if (arready) begin
          state_d = RSP;
        end
      end
      RSP:  if (rvalid) state_d = OUT;
      OUT:  if (ifu_accept) state_d = DEC;
      DEC:  state_d = (err_q || jump) ? WAIT : REQ;
      WAIT: if (redirect_valid) state_d = REQ;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pc_d   = pc_q;
    inst_d = inst_q;
    ipc_d  = ipc_q;
    err_d  = err_q;
    case (state_q)
      REQ: begin
        if (misaligned) begin
          inst_d = 32'h0;
          ipc_d  = pc_q;
          err_d  = 1'b1;
        end
      end
      RSP: begin
        if (rvalid) begin
          inst_d = rdata;
          ipc_d  = pc_q;
          err_d  = (rresp != 2'b00);
        end
      end
      DEC:  if (!err_q && !jump) pc_d = pc_q + 32'd4;
      WAIT: if (redirect_valid) pc_d = redirect_pc;
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q   <= RESET_PC;
      inst_q <= 32'h0;
      ipc_q  <= RESET_PC;
      err_q  <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      inst_q <= inst_d;
      ipc_q  <= ipc_d;
      err_q  <= err_d;
    end
  end

  always_comb begin
    arvalid   = 1'b0;
    rready    = 1'b0;
    ifu_valid = 1'b0;
    case (state_q)
      REQ:     arvalid   = !misaligned;
      RSP:     rready    = 1'b1;
      OUT:     ifu_valid = 1'b1;
      default: ;
    endcase
  end

  assign araddr    = pc_q;
  assign ifu_inst  = inst_q;
  assign ifu_pc    = ipc_q;
  assign fetch_err = err_q;

endmodule

// File: tb/tb_ysyx_25040111_ifu.sv
// Directed bench for ysyx_25040111_ifu with a delay-configurable read slave.
module tb_ysyx_25040111_ifu;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clock;
  logic        reset;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic [31:0] ifu_inst;
  logic [31:0] ifu_pc;
  logic        ifu_valid;
  logic        ifu_accept;
  logic        fetch_err;
  logic        jump;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  logic        slv_rvalid;
  logic [31:0] slv_rdata;
  logic        stale_rv;
  logic [31:0] stale_dat;
  logic [31:0] lat_addr;
  logic [31:0] err_addr;
  logic        pend;
  int          cnt;
  int          ar_dly;
  int          r_dly;
  logic [31:0] ar_log[$];

  int n_tests;
  int n_fail;
  int base;

  assign rvalid = slv_rvalid | stale_rv;
  assign rdata  = stale_rv ? stale_dat : slv_rdata;

  ysyx_25040111_ifu dut (
    .clock          (clock),
    .reset          (reset),
    .araddr         (araddr),
    .arvalid        (arvalid),
    .arready        (arready),
    .rvalid         (rvalid),
    .rready         (rready),
    .rdata          (rdata),
    .rresp          (rresp),
    .ifu_inst       (ifu_inst),
    .ifu_pc         (ifu_pc),
    .ifu_valid      (ifu_valid),
    .ifu_accept     (ifu_accept),
    .fetch_err      (fetch_err),
    .jump           (jump),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n = 0;
    while (!ifu_valid && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (!ifu_valid) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_ar(input string tag, input int target, input int budget);
    int n = 0;
    while ((ar_log.size() - base) < target && n < budget) begin
      @(negedge clock);
      n++;
    end
    if ((ar_log.size() - base) < target) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic drive_r();
    slv_rvalid = 1'b1;
    slv_rdata  = NOP;
    rresp      = (lat_addr == err_addr) ? 2'b10 : 2'b00;
  endtask

  // Read slave: decides on the falling edge, DUT samples on the rising edge.
  initial begin
    arready = 1'b0; slv_rvalid = 1'b0; slv_rdata = 32'h0; rresp = 2'b00;
    pend = 1'b0; cnt = 0; lat_addr = 32'h0;
    forever begin
      @(negedge clock);
      if (reset) begin
        arready = 1'b0; slv_rvalid = 1'b0; pend = 1'b0; cnt = 0;
      end else if (arready) begin
        arready = 1'b0; cnt = 0;
        if (r_dly == 0) drive_r();
        else pend = 1'b1;
      end else if (slv_rvalid) begin
        slv_rvalid = 1'b0;
      end else if (pend) begin
        if (cnt >= r_dly) begin
          drive_r(); pend = 1'b0; cnt = 0;
        end else cnt++;
      end else if (arvalid) begin
        if (cnt >= ar_dly) begin
          arready = 1'b1; lat_addr = araddr; ar_log.push_back(araddr); cnt = 0;
        end else cnt++;
      end
    end
  end

  task automatic hold_reset();
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
  endtask

  task automatic release_reset();
    reset = 1'b0;
    base  = ar_log.size();
  endtask

  task automatic pulse_redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    @(negedge clock);
    redirect_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [12:0] vmask;
    logic        ok;
    logic [31:0] hold_inst;
    logic [31:0] hold_pc;
    int          vcount;
    int          found;
    n_tests = 0; n_fail = 0; base = 0;
    reset = 1'b0; ifu_accept = 1'b0; jump = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    stale_rv = 1'b0; stale_dat = 32'h0; ar_dly = 0; r_dly = 0; err_addr = 32'hFFFF_FFFF;
    #1 reset = 1'b1;

    // 1: reset values, then zero-wait streaming
    ifu_accept = 1'b1;
    hold_reset();
    chk("rst_arvalid", {31'd0, arvalid}, 32'd0);
    chk("rst_rready", {31'd0, rready}, 32'd0);
    chk("rst_ifu_valid", {31'd0, ifu_valid}, 32'd0);
    chk("rst_fetch_err", {31'd0, fetch_err}, 32'd0);
    chk("rst_ifu_inst", ifu_inst, 32'h0);
    chk("rst_ifu_pc", ifu_pc, RST_PC);
    chk("rst_araddr", araddr, RST_PC);
    release_reset();
    vmask = '0; vcount = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clock);
      vmask[k] = ifu_valid;
      if (k == 1) begin
        chk("t1_first_arvalid", {31'd0, arvalid}, 32'd1);
        chk("t1_first_araddr", araddr, RST_PC);
      end
      if (ifu_valid) begin
        chk("t1_ifu_pc", ifu_pc, RST_PC + 32'(4 * vcount));
        chk("t1_ifu_inst", ifu_inst, NOP);
        chk("t1_fetch_err", {31'd0, fetch_err}, 32'd0);
        vcount++;
      end
    end
    chk("t1_valid_pattern", {19'd0, vmask}, 32'h0000_0888);
    chk("t1_ar_count", ar_log.size() - base, 32'd3);
    chk("t1_ar0", ar_log[base], 32'h8000_0000);
    chk("t1_ar1", ar_log[base + 1], 32'h8000_0004);
    chk("t1_ar2", ar_log[base + 2], 32'h8000_0008);

    // 2: slow slave, stalled decode
    ifu_accept = 1'b0; ar_dly = 3; r_dly = 5;
    hold_reset();
    release_reset();
    ok = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      if (arvalid !== 1'b1 || araddr !== RST_PC) ok = 1'b0;
    end
    chk("t2_araddr_stable", {31'd0, ok}, 32'd1);
    wait_valid("t2_valid", 20);
    chk("t2_ar_count", ar_log.size() - base, 32'd1);
    chk("t2_ifu_inst", ifu_inst, NOP);
    chk("t2_ifu_pc", ifu_pc, RST_PC);
    hold_inst = ifu_inst; hold_pc = ifu_pc; ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      if (ifu_valid !== 1'b1 || ifu_inst !== NOP || ifu_pc !== RST_PC || arvalid !== 1'b0) ok = 1'b0;
    end
    chk("t2_hold_stable", {31'd0, ok}, 32'd1);
    chk("t2_no_second_ar", ar_log.size() - base, 32'd1);
    ifu_accept = 1'b1;
    @(negedge clock);
    chk("t2_valid_drop", {31'd0, ifu_valid}, 32'd0);

    // 3: jump parks the IFU until redirect
    ar_dly = 0; r_dly = 0; jump = 1'b1; ifu_accept = 1'b1;
    hold_reset();
    release_reset();
    wait_valid("t3_valid", 10);
    repeat (2) @(negedge clock);
    ok = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (arvalid !== 1'b0) ok = 1'b0;
    end
    chk("t3_no_ar_in_wait", {31'd0, ok}, 32'd1);
    chk("t3_ar_count", ar_log.size() - base, 32'd1);
    pulse_redirect(32'h8000_1000);
    jump = 1'b0;
    wait_ar("t3_ar", 2, 10);
    chk("t3_redirect_addr", ar_log[base + 1], 32'h8000_1000);
    wait_valid("t3_valid2", 10);
    chk("t3_redirect_pc", ifu_pc, 32'h8000_1000);

    // 4: bus error, plus a stray redirect outside WAIT
    err_addr = 32'h8000_0010;
    hold_reset();
    release_reset();
    repeat (2) @(negedge clock);
    pulse_redirect(32'h1234_5678);
    found = 0;
    for (int k = 0; k < 40 && found == 0; k++) begin
      if (ifu_valid && ifu_pc == 32'h8000_0010) found = 1;
      else @(negedge clock);
    end
    chk("t4_reached_err_pc", found, 32'd1);
    chk("t4_fetch_err", {31'd0, fetch_err}, 32'd1);
    chk("t4_err_pc", ifu_pc, 32'h8000_0010);
    repeat (8) @(negedge clock);
    chk("t4_wait_no_ar", ar_log.size() - base, 32'd5);
    pulse_redirect(32'h8000_0100);
    wait_ar("t4_ar", 6, 10);
    chk("t4_resume_addr", ar_log[base + 5], 32'h8000_0100);
    err_addr = 32'hFFFF_FFFF;

    // 5: misaligned redirect target
    jump = 1'b1;
    hold_reset();
    release_reset();
    wait_valid("t5_valid", 10);
    repeat (2) @(negedge clock);
    pulse_redirect(32'h8000_0002);
    jump = 1'b0;
    wait_valid("t5_valid2", 10);
    chk("t5_fetch_err", {31'd0, fetch_err}, 32'd1);
    chk("t5_ifu_inst", ifu_inst, 32'h0);
    chk("t5_ifu_pc", ifu_pc, 32'h8000_0002);
    chk("t5_no_ar", ar_log.size() - base, 32'd1);

    // 6: reset during RSP with a stale response arriving under reset
    r_dly = 20;
    hold_reset();
    release_reset();
    repeat (3) @(negedge clock);
    chk("t6_in_rsp", {31'd0, rready}, 32'd1);
    reset = 1'b1;
    #1;
    chk("t6_rst_rready", {31'd0, rready}, 32'd0);
    chk("t6_rst_arvalid", {31'd0, arvalid}, 32'd0);
    chk("t6_rst_ifu_pc", ifu_pc, RST_PC);
    @(negedge clock);
    stale_rv = 1'b1; stale_dat = 32'hDEAD_BEEF;
    repeat (2) @(negedge clock);
    stale_rv = 1'b0; r_dly = 0;
    release_reset();
    wait_valid("t6_valid", 10);
    chk("t6_first_ar", ar_log[base], RST_PC);
    chk("t6_ifu_inst", ifu_inst, NOP);
    chk("t6_ifu_pc", ifu_pc, RST_PC);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
